// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases sys_rst.
// Build option: define RSTSEQ_LOCK_FILTER_EN to ignore lock dropouts shorter than 4 cycles in RUN/SW_RST.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned SW_RST_CYCLES  = 32,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             sw_reset_req,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] fault_cnt,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_SW_RST    = 3'd4
  } state_t;

  // One shared dwell counter, sized for the longest of the timed states.
  localparam int unsigned SPAN_A = (PLL_RST_CYCLES > SW_RST_CYCLES) ? PLL_RST_CYCLES : SW_RST_CYCLES;
  localparam int unsigned SPAN_B = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int unsigned SPAN   = (SPAN_A > SPAN_B) ? SPAN_A : SPAN_B;
  localparam int unsigned CTR_W  = (SPAN > 1) ? $clog2(SPAN) : 1;

  localparam logic [CTR_W-1:0] PLL_RST_LAST = CTR_W'(PLL_RST_CYCLES - 1);
  localparam logic [CTR_W-1:0] TIMEOUT_LAST = CTR_W'(LOCK_TIMEOUT - 1);
  localparam logic [CTR_W-1:0] STABLE_LAST  = CTR_W'(STABLE_CYCLES - 1);
  localparam logic [CTR_W-1:0] SW_RST_LAST  = CTR_W'(SW_RST_CYCLES - 1);

  state_t           state;
  state_t           nxt;
  logic [CTR_W-1:0] cnt;
  logic             lock_meta;
  logic             lock_s;
  logic             lock_lost;
  logic             fault_inc;

  // pll_locked comes from another clock domain; every decision below uses lock_s only.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

`ifdef RSTSEQ_LOCK_FILTER_EN
  logic [1:0] drop_cnt;

  // Counts prior consecutive low lock_s cycles while running; the 4th low cycle is a real loss.
  always_ff @(posedge refclk) begin
    if (rst) begin
      drop_cnt <= 2'd0;
    end else if (lock_s || !(state == S_RUN || state == S_SW_RST)) begin
      drop_cnt <= 2'd0;
    end else if (drop_cnt != 2'd3) begin
      drop_cnt <= drop_cnt + 2'd1;
    end
  end

  assign lock_lost = !lock_s && (drop_cnt == 2'd3);
`else
  assign lock_lost = !lock_s;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    nxt       = state;
    fault_inc = 1'b0;
    case (state)
      S_PLL_RST: begin
        if (cnt == PLL_RST_LAST) nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          nxt = S_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          nxt       = S_PLL_RST;
          fault_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s)                   nxt = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST)   nxt = S_RUN;
      end
      S_RUN: begin
        if (lock_lost) begin
          nxt       = S_PLL_RST;
          fault_inc = 1'b1;
        end else if (sw_reset_req) begin
          nxt = S_SW_RST;
        end
      end
      S_SW_RST: begin
        if (lock_lost) begin
          nxt       = S_PLL_RST;
          fault_inc = 1'b1;
        end else if (cnt == SW_RST_LAST) begin
          nxt = S_RUN;
        end
      end
      default: nxt = S_PLL_RST;
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as the state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault_cnt <= '0;
    end else begin
      state   <= nxt;
      cnt     <= (nxt != state) ? '0 : cnt + CTR_W'(1);
      pll_rst <= (nxt == S_PLL_RST);
      sys_rst <= (nxt != S_RUN);
      ready   <= (nxt == S_RUN);
      if (fault_inc && (fault_cnt != '1)) fault_cnt <= fault_cnt + CNT_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus random stimulus against a
// cycle-level behavioural model of the sequencing rules. Honours RSTSEQ_LOCK_FILTER_EN if defined.
module tb_pll_reset_sequencer;

  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 64;
  localparam int STABLE_CYCLES  = 8;
  localparam int SW_RST_CYCLES  = 5;
  localparam int CNT_W          = 4;
  localparam int FAULT_MAX      = (1 << CNT_W) - 1;
`ifdef RSTSEQ_LOCK_FILTER_EN
  localparam int LOSS_N = 4;
`else
  localparam int LOSS_N = 1;
`endif

  logic             refclk;
  logic             rst;
  logic             pll_locked;
  logic             sw_reset_req;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic [CNT_W-1:0] fault_cnt;
  logic [2:0]       state_o;

  int checks = 0;
  int fails  = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .SW_RST_CYCLES (SW_RST_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .sw_reset_req(sw_reset_req),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .fault_cnt   (fault_cnt),
    .state_o     (state_o)
  );

  initial begin
    refclk = 1'b0;
    forever #10 refclk = ~refclk;
  end

  // Behavioural model: states are the numbers 0..4 (PLL_RST, WAIT_LOCK, STABLE, RUN, SW_RST).
  int m_state = 0;
  int m_edges = 0;   // edges already evaluated in the current state
  int m_fault = 0;
  int m_zeros = 0;   // consecutive low lock samples while running
  bit m_s1    = 1'b0;
  bit m_s2    = 1'b0;

  function automatic void model_step();
    bit lk;
    int n;
    int next;
    bit bump;
    lk   = m_s2;
    bump = 1'b0;
    if (rst) begin
      m_state = 0; m_edges = 0; m_fault = 0; m_zeros = 0; m_s1 = 1'b0; m_s2 = 1'b0;
      return;
    end
    m_s2 = m_s1;
    m_s1 = pll_locked;
    n    = m_edges + 1;
    if ((m_state == 3 || m_state == 4) && !lk) m_zeros++;
    else m_zeros = 0;
    next = m_state;
    case (m_state)
      0: if (n >= PLL_RST_CYCLES) next = 1;
      1: if (lk) next = 2; else if (n >= LOCK_TIMEOUT) begin next = 0; bump = 1'b1; end
      2: if (!lk) next = 1; else if (n >= STABLE_CYCLES) next = 3;
      3: if (m_zeros >= LOSS_N) begin next = 0; bump = 1'b1; end else if (sw_reset_req) next = 4;
      4: if (m_zeros >= LOSS_N) begin next = 0; bump = 1'b1; end else if (n >= SW_RST_CYCLES) next = 3;
      default: next = 0;
    endcase
    if (bump && m_fault < FAULT_MAX) m_fault++;
    if (next != m_state) begin
      m_state = next;
      m_edges = 0;
    end else begin
      m_edges = n;
    end
  endfunction

  function automatic logic [9:0] exp_vec();
    logic [2:0] s;
    logic [3:0] f;
    s = m_state[2:0];
    f = m_fault[3:0];
    return {s, m_state == 0, m_state != 3, m_state == 3, f};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {state_o, pll_rst, sys_rst, ready, fault_cnt};
  endfunction

  task automatic tick();
    @(posedge refclk);
    model_step();
    @(negedge refclk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sw_reset_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_reset_req = 1'b0; pll_locked = 1'b1;
    tick();
    tick();
    checks++;
    if (obs_vec() !== 10'b000_1_1_0_0000) begin
      fails++; $display("FAIL reset_values: got %b expected %b", obs_vec(), 10'b000_1_1_0_0000);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset_model: got %b expected %b", obs_vec(), exp_vec());
    end
  endtask

  // Sample k is taken just before edge k; edge 0 was the last reset edge.
  task automatic test_clean_bringup();
    logic [6:0] want;
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      want = {k <= 4, k < 14, k >= 14, 4'd0};
      checks++;
      if ({pll_rst, sys_rst, ready, fault_cnt} !== want) begin
        fails++; $display("FAIL bringup_edge%0d: got %b expected %b", k, {pll_rst, sys_rst, ready, fault_cnt}, want);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL bringup_model edge%0d: got %b expected %b", k, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_lock_timeout();
    int pulses = 0;
    bit reached = 1'b0;
    pll_locked = 1'b0;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 150) pll_locked = 1'b1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL timeout_model cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      if (pll_rst) pulses++;
      if (ready) begin reached = 1'b1; break; end
      tick();
    end
    checks++;
    if (!reached) begin fails++; $display("FAIL timeout_reach_run: got ready=0 expected ready=1 within 400 cycles"); end
    checks++;
    if (fault_cnt !== 4'd2) begin fails++; $display("FAIL timeout_fault_cnt: got %0d expected 2", fault_cnt); end
    checks++;
    if (pulses != 12) begin fails++; $display("FAIL timeout_pll_rst_cycles: got %0d expected 12", pulses); end
  endtask

  task automatic test_unstable_lock();
    bit dropped = 1'b0;
    bit saw_wait = 1'b0;
    bit reached = 1'b0;
    int run = 0;
    int last_run = -1;
    pll_locked = 1'b1;
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      pll_locked = 1'b1;
      if (!dropped && m_state == 2 && m_edges == 5) begin
        pll_locked = 1'b0;
        dropped = 1'b1;
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL unstable_model cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      if (dropped && state_o == 3'd1) saw_wait = 1'b1;
      if (state_o == 3'd2) run++;
      else if (state_o == 3'd3) begin last_run = run; reached = 1'b1; break; end
      else run = 0;
      tick();
    end
    pll_locked = 1'b1;
    checks++;
    if (!(dropped && saw_wait)) begin fails++; $display("FAIL unstable_back_to_wait: got saw_wait=%0d expected 1", saw_wait); end
    checks++;
    if (!reached || last_run != STABLE_CYCLES) begin
      fails++; $display("FAIL unstable_fresh_stable: got %0d stable cycles expected %0d", last_run, STABLE_CYCLES);
    end
    checks++;
    if (fault_cnt !== 4'd0) begin fails++; $display("FAIL unstable_fault_cnt: got %0d expected 0", fault_cnt); end
  endtask

  task automatic test_lock_loss_run();
    int f0;
    int hit = -1;
    pll_locked = 1'b1;
    checks++;
    if (ready !== 1'b1) begin fails++; $display("FAIL lossrun_start_ready: got %b expected 1", ready); end
`ifdef RSTSEQ_LOCK_FILTER_EN
    for (int i = 0; i < 12; i++) begin
      pll_locked = (i >= 3);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL filter_short_model cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (ready !== 1'b1) begin fails++; $display("FAIL filter_short_drop_ignored: got ready=%b expected 1", ready); end
`endif
    f0 = m_fault;
    for (int e = 1; e <= 10; e++) begin
      pll_locked = (e > LOSS_N);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL lossrun_model edge%0d: got %b expected %b", e, obs_vec(), exp_vec());
      end
      if (hit < 0 && pll_rst && sys_rst) hit = e;
    end
    checks++;
    if (hit != 2 + LOSS_N) begin fails++; $display("FAIL lossrun_latency: got %0d edges expected %0d", hit, 2 + LOSS_N); end
    checks++;
    if (fault_cnt !== 4'(f0 + 1)) begin fails++; $display("FAIL lossrun_fault_cnt: got %0d expected %0d", fault_cnt, f0 + 1); end
  endtask

  task automatic test_sw_reset();
    int hi = 0;
    bit pll_seen = 1'b0;
    bit back = 1'b0;
    bit reached = 1'b0;
    int f0;
    pll_locked = 1'b1;
    for (int i = 0; i < 100 && !reached; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL swrst_pre_model cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      reached = ready;
    end
    checks++;
    if (!reached) begin fails++; $display("FAIL swrst_reach_run: got ready=0 expected ready=1 within 100 cycles"); end
    sw_reset_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      sw_reset_req = (i == 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL swrst_model cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      if (sys_rst) hi++;
      if (pll_rst) pll_seen = 1'b1;
      if (ready) begin back = 1'b1; break; end
    end
    sw_reset_req = 1'b0;
    checks++;
    if (!back || hi != SW_RST_CYCLES) begin
      fails++; $display("FAIL swrst_hold_len: got %0d cycles (back=%0d) expected %0d", hi, back, SW_RST_CYCLES);
    end
    checks++;
    if (pll_seen) begin fails++; $display("FAIL swrst_pll_untouched: got pll_rst=1 expected 0"); end
    // Lock loss recognised on the same edge as a request: the loss must win.
    f0 = m_fault;
    for (int j = 0; j <= LOSS_N + 1; j++) begin
      pll_locked   = (j >= LOSS_N);
      sw_reset_req = (j == LOSS_N + 1);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL swrst_tie_model edge%0d: got %b expected %b", j, obs_vec(), exp_vec());
      end
    end
    sw_reset_req = 1'b0;
    checks++;
    if ({state_o, pll_rst, fault_cnt} !== {3'd0, 1'b1, 4'(f0 + 1)}) begin
      fails++; $display("FAIL swrst_tie_loss_wins: got %b expected %b", {state_o, pll_rst, fault_cnt}, {3'd0, 1'b1, 4'(f0 + 1)});
    end
  endtask

  task automatic test_saturation_midreset();
    bit in_stable = 1'b0;
    pll_locked = 1'b0;
    apply_reset();
    for (int i = 0; i < 20 * (PLL_RST_CYCLES + LOCK_TIMEOUT) + 20; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL sat_model cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      tick();
    end
    checks++;
    if (fault_cnt !== 4'd15) begin fails++; $display("FAIL sat_fault_cnt: got %0d expected 15", fault_cnt); end
    pll_locked = 1'b1;
    for (int i = 0; i < 200 && !in_stable; i++) begin
      tick();
      in_stable = (state_o == 3'd2);
    end
    checks++;
    if (!in_stable) begin fails++; $display("FAIL midrst_reach_stable: got state %0d expected 2", state_o); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== 10'b000_1_1_0_0000) begin
      fails++; $display("FAIL midrst_values: got %b expected %b", obs_vec(), 10'b000_1_1_0_0000);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int low_len = 0;
    pll_locked = 1'b1;
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      if (low_len == 0 && $urandom_range(0, 149) == 0) low_len = $urandom_range(1, 90);
      pll_locked   = (low_len == 0);
      if (low_len > 0) low_len--;
      sw_reset_req = ($urandom_range(0, 23) == 0);
      rst          = ($urandom_range(0, 1499) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL random_model cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0;
    sw_reset_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b1;
    sw_reset_req = 1'b0;
    test_reset();
    test_clean_bringup();
    test_lock_timeout();
    test_unstable_lock();
    test_lock_loss_run();
    test_sw_reset();
    test_saturation_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
